// File: rtl/mips_pkg.sv
// Shared constants and types for the register-file write path.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH-entry FIFO; exposes every slot in age order (0 = oldest)
// so the owner can search pending entries.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [CW-1:0]                count,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             tap_valid,
  output logic [DEPTH-1:0][WIDTH-1:0]  tap_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; count disambiguates full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tap_data[i]  = mem[rd_ptr + PW'(i)];
      tap_valid[i] = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Buffers ALU and load results and drains them one per cycle into the
// register-file write port, with forwarding of still-pending values.
module wb_write_queue #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DEPTH  = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              wb_stall,
  output logic              RegisterWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeBack,
  input  logic [ADDR_W-1:0] fwd_reg1,
  input  logic [ADDR_W-1:0] fwd_reg2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int EW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(mips_pkg::REG_ZERO);

  logic                      ld_fire;
  logic                      alu_fire;
  logic                      push;
  logic                      pop;
  logic [EW-1:0]             push_data;
  logic [EW-1:0]             head;
  logic [DEPTH-1:0]          tap_valid;
  logic [DEPTH-1:0][EW-1:0]  tap_data;

  // Load wins arbitration; writes to r0 complete the handshake but are dropped.
  assign ld_ready  = ~full;
  assign alu_ready = ~full & ~ld_valid;
  assign ld_fire   = ld_valid & ld_ready;
  assign alu_fire  = alu_valid & alu_ready;
  assign push      = (ld_fire && ld_reg != REG_ZERO) || (alu_fire && alu_reg != REG_ZERO);
  assign push_data = ld_valid ? {ld_reg, ld_data} : {alu_reg, alu_data};
  assign pop       = ~empty & ~wb_stall;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .tap_valid (tap_valid),
    .tap_data  (tap_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegisterWrite <= 1'b0;
      writeRegister <= '0;
      writeBack     <= '0;
    end else begin
      RegisterWrite <= pop;
      if (pop) begin
        writeRegister <= head[EW-1 -: ADDR_W];
        writeBack     <= head[DATA_W-1:0];
      end
    end
  end

  // Later matches override earlier ones, so the youngest entry wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] idx);
    logic [DATA_W:0] res;
    res = '0;
    if (RegisterWrite && writeRegister == idx) res = {1'b1, writeBack};
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_valid[i] && tap_data[i][EW-1 -: ADDR_W] == idx)
        res = {1'b1, tap_data[i][DATA_W-1:0]};
    end
    if (idx == REG_ZERO) res = '0;
    return res;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(fwd_reg1);
    {fwd_hit2, fwd_data2} = lookup(fwd_reg2);
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: queue-based reference model plus
// a write scoreboard fed at acceptance and drained by a negedge monitor.
module tb_wb_write_queue;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic        alu_valid = 1'b0;
  logic        wb_stall = 1'b0;
  logic [4:0]  ld_reg = '0;
  logic [4:0]  alu_reg = '0;
  logic [4:0]  fwd_reg1 = '0;
  logic [4:0]  fwd_reg2 = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] alu_data = '0;

  logic        ld_ready;
  logic        alu_ready;
  logic        RegisterWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeBack;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  wb_write_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_reg        (ld_reg),
    .ld_data       (ld_data),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_reg       (alu_reg),
    .alu_data      (alu_data),
    .wb_stall      (wb_stall),
    .RegisterWrite (RegisterWrite),
    .writeRegister (writeRegister),
    .writeBack     (writeBack),
    .fwd_reg1      (fwd_reg1),
    .fwd_reg2      (fwd_reg2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
    .count         (count),
    .full          (full),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  // Reference model state: pending queue, output stage and write scoreboard.
  wb_entry     model_q[$];
  wb_entry     sb_q[$];
  logic        out_valid = 1'b0;
  logic [4:0]  out_reg = '0;
  logic [31:0] out_data = '0;
  logic        ld_acc = 1'b0;
  logic        alu_acc = 1'b0;
  logic        checking = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    wb_entry e;
    if (!rst) begin
      model_q.delete();
      sb_q.delete();
      out_valid = 1'b0;
      out_reg   = '0;
      out_data  = '0;
      ld_acc    = 1'b0;
      alu_acc   = 1'b0;
    end else begin
      ld_acc  = ld_valid && (model_q.size() < DEPTH);
      alu_acc = alu_valid && (model_q.size() < DEPTH) && !ld_valid;
      if (model_q.size() > 0 && !wb_stall) begin
        e         = model_q.pop_front();
        out_valid = 1'b1;
        out_reg   = e.dst;
        out_data  = e.data;
      end else begin
        out_valid = 1'b0;
      end
      if (ld_acc && ld_reg != 5'd0) begin
        model_q.push_back('{dst: ld_reg, data: ld_data});
        sb_q.push_back('{dst: ld_reg, data: ld_data});
      end else if (alu_acc && alu_reg != 5'd0) begin
        model_q.push_back('{dst: alu_reg, data: alu_data});
        sb_q.push_back('{dst: alu_reg, data: alu_data});
      end
    end
  end

  function automatic logic [32:0] expFwd(input logic [4:0] r);
    logic [32:0] res;
    res = '0;
    if (r == 5'd0) return res;
    if (out_valid && out_reg == r) res = {1'b1, out_data};
    foreach (model_q[i]) if (model_q[i].dst == r) res = {1'b1, model_q[i].data};
    return res;
  endfunction

  always @(negedge clk) begin
    wb_entry     e;
    logic [32:0] f1;
    logic [32:0] f2;
    if (checking) begin
      checkOutput("count", count, model_q.size());
      checkOutput("empty", empty, model_q.size() == 0);
      checkOutput("full", full, model_q.size() == DEPTH);
      checkOutput("ld_ready", ld_ready, model_q.size() < DEPTH);
      checkOutput("alu_ready", alu_ready, (model_q.size() < DEPTH) && !ld_valid);
      checkOutput("RegisterWrite", RegisterWrite, out_valid);
      checkOutput("writeRegister", writeRegister, out_reg);
      checkOutput("writeBack", writeBack, out_data);
      if (RegisterWrite) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_write", RegisterWrite, 1'b0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_reg", writeRegister, e.dst);
          checkOutput("sb_data", writeBack, e.data);
        end
      end
      f1 = expFwd(fwd_reg1);
      f2 = expFwd(fwd_reg2);
      checkOutput("fwd_hit1", fwd_hit1, f1[32]);
      checkOutput("fwd_hit2", fwd_hit2, f2[32]);
      if (f1[32] || fwd_reg1 == 5'd0) checkOutput("fwd_data1", fwd_data1, f1[31:0]);
      if (f2[32] || fwd_reg2 == 5'd0) checkOutput("fwd_data2", fwd_data2, f2[31:0]);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (ld_acc) ld_valid = 1'b0;
    if (alu_acc) alu_valid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    wb_stall = 1'b0;
    while ((ld_valid || alu_valid || model_q.size() != 0 || out_valid) && n < limit) begin
      stepCycle();
      n++;
    end
    vectors++;
    if (ld_valid || alu_valid || model_q.size() != 0 || out_valid) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout: queue still busy after %0d cycles", limit);
    end
  endtask

  task automatic applyStimulus();
    stepCycle();
    if (!ld_valid && $urandom_range(0, 99) < 30) begin
      ld_valid = 1'b1;
      ld_reg   = 5'($urandom_range(0, 7));
      ld_data  = $urandom;
    end
    if (!alu_valid && $urandom_range(0, 99) < 45) begin
      alu_valid = 1'b1;
      alu_reg   = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
    end
    wb_stall = ($urandom_range(0, 99) < 30);
    fwd_reg1 = 5'($urandom_range(0, 7));
    fwd_reg2 = 5'($urandom_range(0, 7));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    checkOutput("reset_RegisterWrite", RegisterWrite, 1'b0);
    checkOutput("reset_empty", empty, 1'b1);
    checkOutput("reset_full", full, 1'b0);
    rst = 1'b1;
    stepCycle();

    // Single write latency and forwarding window.
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF; fwd_reg1 = 5'd5;
    stepCycle();
    checkOutput("lat_fwd_pending", fwd_hit1, 1'b1);
    checkOutput("lat_no_write_yet", RegisterWrite, 1'b0);
    stepCycle();
    checkOutput("lat_write", RegisterWrite, 1'b1);
    checkOutput("lat_reg", writeRegister, 5'd5);
    checkOutput("lat_data", writeBack, 32'hDEADBEEF);
    checkOutput("lat_fwd_outstage", fwd_hit1, 1'b1);
    stepCycle();
    checkOutput("lat_write_done", RegisterWrite, 1'b0);
    checkOutput("lat_fwd_gone", fwd_hit1, 1'b0);

    // Load priority over ALU.
    ld_valid = 1'b1; ld_reg = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h22;
    #1;
    checkOutput("prio_alu_blocked", alu_ready, 1'b0);
    stepCycle();
    checkOutput("prio_alu_waiting", alu_valid, 1'b1);
    waitIdle(20);

    // Youngest pending value forwards.
    wb_stall = 1'b1;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hA;
    stepCycle();
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hB;
    stepCycle();
    fwd_reg1 = 5'd7;
    #1;
    checkOutput("young_hit", fwd_hit1, 1'b1);
    checkOutput("young_data", fwd_data1, 32'hB);
    waitIdle(20);

    // Fill under stall, hold a fifth request, then drain.
    wb_stall = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      ld_valid = 1'b1; ld_reg = 5'(k + 1); ld_data = 32'(100 + k);
      stepCycle();
    end
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h55;
    #1;
    checkOutput("full_flag", full, 1'b1);
    checkOutput("full_ld_ready", ld_ready, 1'b0);
    checkOutput("full_alu_ready", alu_ready, 1'b0);
    repeat (2) stepCycle();
    checkOutput("full_count_held", count, 3'd4);
    waitIdle(30);

    // Register zero handshake drops the write.
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF; fwd_reg1 = 5'd0;
    stepCycle();
    checkOutput("zero_count", count, 3'd0);
    checkOutput("zero_fwd_hit", fwd_hit1, 1'b0);
    checkOutput("zero_fwd_data", fwd_data1, 32'd0);
    repeat (3) stepCycle();

    // Reset in the middle of a drain.
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_reg = 5'(10 + k); alu_data = 32'(200 + k);
      stepCycle();
    end
    wb_stall = 1'b0;
    fwd_reg1 = 5'd11;
    stepCycle();
    checkOutput("mid_drain_write", RegisterWrite, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("rst_RegisterWrite", RegisterWrite, 1'b0);
    checkOutput("rst_count", count, 3'd0);
    checkOutput("rst_fwd_hit", fwd_hit1, 1'b0);
    stepCycle();
    rst = 1'b1;
    repeat (5) stepCycle();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) applyStimulus();
    waitIdle(200);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
